jtag_gpio_bank: RTL
===================

Name: jtag_gpio_bank

Overview:
- Next-generation JTAG-controlled GPIO bank, clocked entirely in the TCK domain, driven by a real or virtual TAP.
- Provides three DR scan chains selected by IR decode:
  - data: capture synchronised inputs, update outputs.
  - config: output enables.
  - edge: sticky input-change status, write-1-to-clear.
- Adds input synchronisers, sticky edge detection and scan-length checking, so that truncated or overlong scans never corrupt outputs.

Parameters:
- NR_GPIOS, 8: number of GPIO bits; range 1..64.
- SYNC_STAGES, 2: synchroniser flops on gpio_inputs; 0 = bypass, range 0..3.
- OUT_RESET_VAL, 0: reset value of gpio_outputs, NR_GPIOS bits.

Ports:
- tck  input  1  JTAG clock; all state is on posedge tck.
- reset  input  1  synchronous active-high reset.
- tdi  input  1  serial data in.
- gpios_tdo  output  1  serial data out; equals gpio_dr[0].
- capture_dr  input  1  TAP in Capture-DR.
- shift_dr  input  1  TAP in Shift-DR.
- update_dr  input  1  TAP in Update-DR.
- gpio_data_ir  input  1  data chain selected.
- gpio_config_ir  input  1  config chain selected.
- gpio_edge_ir  input  1  edge chain selected.
- gpio_inputs  input  NR_GPIOS  asynchronous pad inputs.
- gpio_outputs  output  NR_GPIOS  output values, registered.
- gpio_outputs_ena  output  NR_GPIOS  output enables, registered; 1 = drive.
- scan_len_err  output  1  sticky flag: an update was rejected for bad scan length.

Behaviour:
- Clock and reset: one clock (tck); reset is synchronous and active-high.
- Reset values:
  - gpio_outputs = OUT_RESET_VAL.
  - gpio_outputs_ena = 0.
  - gpio_dr, sync flops, edge_prev, edge_status, shift_cnt, scan_len_err = 0.
  - Reset mid-scan aborts the scan; no commit occurs.
- Synchroniser:
  - gpio_sync is gpio_inputs delayed by SYNC_STAGES tck cycles.
  - SYNC_STAGES = 0 is a direct wire.
- Edge detect:
  - edge_prev <= gpio_sync every cycle.
  - edge_status[i] sets when gpio_sync[i] != edge_prev[i] and stays set until cleared.
  - The first cycle after reset does not generate edges.
- IR select:
  - Priority is data > config > edge; only the highest asserted IR is active.
  - With no IR asserted, capture/shift/update are ignored and gpio_dr holds.
- TAP-state priority when several are asserted in one cycle: capture > shift > update.
- Capture:
  - Loads gpio_dr with gpio_sync (data), gpio_outputs_ena (config) or edge_status (edge).
  - Clears shift_cnt.
- Shift:
  - gpio_dr <= {tdi, gpio_dr[NR_GPIOS-1:1]}.
  - shift_cnt increments and saturates at NR_GPIOS+1; width clog2(NR_GPIOS+2).
- Update, only when shift_cnt == NR_GPIOS:
  - data: gpio_outputs <= gpio_dr.
  - config: gpio_outputs_ena <= gpio_dr.
  - edge: edge_status <= edge_status & ~gpio_dr.
- Update with shift_cnt != NR_GPIOS, including zero-length:
  - No commit.
  - scan_len_err <= 1; it stays sticky until reset.
- Simultaneous edge set and W1C clear on the same bit in the same cycle: set wins, bit stays 1.
- Latency:
  - Committed values appear on outputs one tck after the update_dr cycle.
  - A pad change is visible in capture after SYNC_STAGES+1 cycles.
- gpios_tdo = gpio_dr[0], combinational from the register.

Optional Feature:
- Macro: JTAG_GPIO_EDGE_STATUS_EN.
- Defined: edge chain, edge_prev and edge_status are present as described above.
- Undefined:
  - No edge logic is built and gpio_edge_ir is ignored.
  - IR priority reduces to data > config.

Test Plan:
- Reset, then NR_GPIOS=8 data scan: capture, shift tdi 0xA5 LSB-first over 8 cycles, update -> gpio_outputs=0xA5 next cycle, scan_len_err=0; TDO returns captured gpio_inputs (driven 0x3C, held stable) LSB-first.
- Config scan shifting only 7 bits of 0xFF, then update -> gpio_outputs_ena stays 0x00, scan_len_err=1; a following valid 8-bit scan of 0x0F -> ena=0x0F, scan_len_err remains 1.
- Toggle gpio_inputs[3] 0->1, wait SYNC_STAGES+2 cycles; edge scan capture -> TDO bit 3 = 1; shift 0x08 then update -> edge_status=0.
- Toggle input bit 5 in the same cycle its W1C update occurs (shift 0x20) -> edge_status[5] remains 1.
- Assert reset during Shift-DR of a data scan, then send update without a new capture -> gpio_outputs=OUT_RESET_VAL, scan_len_err=1 (count 0 != 8).
- Assert gpio_data_ir and gpio_config_ir together, scan 0x55 -> only gpio_outputs=0x55; gpio_outputs_ena unchanged.

Source files
------------

// File: rtl/jtag_gpio_bank.sv
// JTAG-controlled GPIO bank in the TCK domain: data, config and (optional) sticky edge scan chains.
// Optional edge chain is built only when JTAG_GPIO_EDGE_STATUS_EN is defined.
module jtag_gpio_bank #(
  parameter int                  NR_GPIOS      = 8,
  parameter int                  SYNC_STAGES   = 2,
  parameter logic [NR_GPIOS-1:0] OUT_RESET_VAL = '0
) (
  input  logic                tck,
  input  logic                reset,
  input  logic                tdi,
  output logic                gpios_tdo,
  input  logic                capture_dr,
  input  logic                shift_dr,
  input  logic                update_dr,
  input  logic                gpio_data_ir,
  input  logic                gpio_config_ir,
  input  logic                gpio_edge_ir,
  input  logic [NR_GPIOS-1:0] gpio_inputs,
  output logic [NR_GPIOS-1:0] gpio_outputs,
  output logic [NR_GPIOS-1:0] gpio_outputs_ena,
  output logic                scan_len_err
);

  localparam int CNT_W = $clog2(NR_GPIOS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NR_GPIOS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NR_GPIOS + 1);

  logic [NR_GPIOS-1:0] gpio_sync;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign gpio_sync = gpio_inputs;
    end else begin : g_sync
      logic [NR_GPIOS-1:0] sync_q [SYNC_STAGES];
      logic [NR_GPIOS-1:0] sync_d [SYNC_STAGES];

      always_comb begin
        sync_d[0] = gpio_inputs;
        for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
      end

      always_ff @(posedge tck) begin
        for (int k = 0; k < SYNC_STAGES; k++) begin
          if (reset) sync_q[k] <= '0;
          else       sync_q[k] <= sync_d[k];
        end
      end

      assign gpio_sync = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [NR_GPIOS-1:0] gpio_dr_q, gpio_dr_d;
  logic [NR_GPIOS-1:0] gpio_outputs_q, gpio_outputs_d;
  logic [NR_GPIOS-1:0] gpio_outputs_ena_q, gpio_outputs_ena_d;
  logic [CNT_W-1:0]    shift_cnt_q, shift_cnt_d;
  logic                scan_len_err_q, scan_len_err_d;
  logic                sel_data, sel_cfg, sel_any;
  logic                commit, reject;
  logic [NR_GPIOS-1:0] cap_val;

`ifdef JTAG_GPIO_EDGE_STATUS_EN
  logic [NR_GPIOS-1:0] edge_prev_q, edge_prev_d;
  logic [NR_GPIOS-1:0] edge_status_q, edge_status_d;
  logic                edge_arm_q, edge_arm_d;
  logic                sel_edge;
  logic [NR_GPIOS-1:0] edge_set, edge_clr;
`else
  logic                unused_edge_ir;
  assign unused_edge_ir = gpio_edge_ir;
`endif

  // IR decode: data outranks config, which outranks edge
  always_comb begin
    sel_data = gpio_data_ir;
    sel_cfg  = gpio_config_ir & ~gpio_data_ir;
    sel_any  = sel_data | sel_cfg;
    cap_val  = '0;
`ifdef JTAG_GPIO_EDGE_STATUS_EN
    sel_edge = gpio_edge_ir & ~gpio_data_ir & ~gpio_config_ir;
    sel_any  = sel_any | sel_edge;
    if (sel_edge) cap_val = edge_status_q;
`endif
    if (sel_cfg)  cap_val = gpio_outputs_ena_q;
    if (sel_data) cap_val = gpio_sync;
    commit = sel_any & ~capture_dr & ~shift_dr & update_dr & (shift_cnt_q == CNT_FULL);
    reject = sel_any & ~capture_dr & ~shift_dr & update_dr & (shift_cnt_q != CNT_FULL);
  end

  always_comb begin
    gpio_dr_d          = gpio_dr_q;
    shift_cnt_d        = shift_cnt_q;
    gpio_outputs_d     = gpio_outputs_q;
    gpio_outputs_ena_d = gpio_outputs_ena_q;
    scan_len_err_d     = scan_len_err_q | reject;
    if (sel_any && capture_dr) begin
      gpio_dr_d   = cap_val;
      shift_cnt_d = '0;
    end else if (sel_any && shift_dr) begin
      gpio_dr_d              = gpio_dr_q >> 1;
      gpio_dr_d[NR_GPIOS-1]  = tdi;
      if (shift_cnt_q != CNT_SAT) shift_cnt_d = shift_cnt_q + 1'b1;
    end
    if (commit && sel_data) gpio_outputs_d     = gpio_dr_q;
    if (commit && sel_cfg)  gpio_outputs_ena_d = gpio_dr_q;
  end

`ifdef JTAG_GPIO_EDGE_STATUS_EN
  // A new edge on a bit beats a simultaneous write-1-to-clear of that bit
  always_comb begin
    edge_set      = edge_arm_q ? (gpio_sync ^ edge_prev_q) : '0;
    edge_clr      = (commit && sel_edge) ? gpio_dr_q : '0;
    edge_status_d = (edge_status_q & ~edge_clr) | edge_set;
    edge_prev_d   = gpio_sync;
    edge_arm_d    = 1'b1;
  end

  always_ff @(posedge tck) begin
    if (reset) begin
      edge_prev_q   <= '0;
      edge_status_q <= '0;
      edge_arm_q    <= 1'b0;
    end else begin
      edge_prev_q   <= edge_prev_d;
      edge_status_q <= edge_status_d;
      edge_arm_q    <= edge_arm_d;
    end
  end
`endif

  always_ff @(posedge tck) begin
    if (reset) begin
      gpio_dr_q          <= '0;
      shift_cnt_q        <= '0;
      gpio_outputs_q     <= OUT_RESET_VAL;
      gpio_outputs_ena_q <= '0;
      scan_len_err_q     <= 1'b0;
    end else begin
      gpio_dr_q          <= gpio_dr_d;
      shift_cnt_q        <= shift_cnt_d;
      gpio_outputs_q     <= gpio_outputs_d;
      gpio_outputs_ena_q <= gpio_outputs_ena_d;
      scan_len_err_q     <= scan_len_err_d;
    end
  end

  assign gpios_tdo        = gpio_dr_q[0];
  assign gpio_outputs     = gpio_outputs_q;
  assign gpio_outputs_ena = gpio_outputs_ena_q;
  assign scan_len_err     = scan_len_err_q;

endmodule
